// File: rtl/sipo_piso_master_pkg.sv
// rtl/sipo_piso_master_pkg.sv - shared frame geometry and FSM encoding for the sipo_piso master
package sipo_piso_master_pkg;

    localparam int CFG_ADDR_WIDTH = 5;
    localparam int CFG_REG_WIDTH  = 8;
    localparam int CFG_FRAME_BITS = CFG_ADDR_WIDTH + CFG_REG_WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_SHIFT  = 3'd3,
        ST_GAP    = 3'd4
    } state_e;

    // A single requester still needs a 1-bit pointer/index.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sipo_piso_master_rr_arbiter.sv
// rtl/sipo_piso_master_rr_arbiter.sv - round-robin arbiter: combinational grant, registered pointer
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int PTR_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] valid_i,
    input  logic             accept_i,
    output logic             gnt_valid_o,
    output logic [PTR_W-1:0] gnt_idx_o,
    output logic [N_REQ-1:0] gnt_oh_o
);

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             hi_found, lo_found;
    logic [PTR_W-1:0] hi_idx, lo_idx;

    // Lowest valid index at/after the pointer wins; otherwise the lowest below it (wrap).
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int r = N_REQ - 1; r >= 0; r--) begin
            if (valid_i[r]) begin
                if (PTR_W'(r) >= ptr_q) begin
                    hi_found = 1'b1;
                    hi_idx   = PTR_W'(r);
                end else begin
                    lo_found = 1'b1;
                    lo_idx   = PTR_W'(r);
                end
            end
        end
        gnt_valid_o = hi_found | lo_found;
        gnt_idx_o   = hi_found ? hi_idx : lo_idx;
        gnt_oh_o    = gnt_valid_o ? (N_REQ'(1) << gnt_idx_o) : '0;
        ptr_d       = ptr_q;
        if (accept_i && gnt_valid_o) begin
            ptr_d = (gnt_idx_o == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx_o + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/sipo_piso_master.sv
// rtl/sipo_piso_master.sv - arbitrates register requests and serialises them into strobe/wr_en/din frames
module sipo_piso_master
    import sipo_piso_master_pkg::*;
#(
    parameter int ADDR_WIDTH = CFG_ADDR_WIDTH,
    parameter int REG_WIDTH  = CFG_REG_WIDTH,
    parameter int N_REQ      = 2,
    parameter int GAP_CYCLES = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ-1:0]            req_write,
    input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [N_REQ*REG_WIDTH-1:0]  req_wdata,
    output logic [N_REQ-1:0]            req_ready,
    output logic [N_REQ-1:0]            rsp_valid,
    output logic [REG_WIDTH-1:0]        rsp_rdata,
    output logic                        busy,
    output logic                        strobe,
    output logic                        wr_en,
    output logic                        din,
    input  logic                        dout
);

    localparam int FRAME_BITS = ADDR_WIDTH + REG_WIDTH;
    localparam int PTR_W      = ptr_width(N_REQ);
    localparam int CNT_MAX    = (FRAME_BITS > GAP_CYCLES) ? FRAME_BITS : GAP_CYCLES;
    localparam int CNT_W      = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] LAST_SLOT  = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] LAST_GAP   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] FIRST_DATA = CNT_W'(ADDR_WIDTH);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [PTR_W-1:0]        gnt_q, gnt_d, gnt_idx;
    logic [N_REQ-1:0]        gnt_oh;
    logic                    gnt_valid, accept;
    logic                    write_q, write_d, sel_write;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d, sel_addr;
    logic [REG_WIDTH-1:0]    wdata_q, wdata_d, sel_wdata;
    logic [REG_WIDTH-2:0]    rdata_q, rdata_d;
    logic [REG_WIDTH-1:0]    sample_word;
    logic [REG_WIDTH-1:0]    rsp_rdata_q, rsp_rdata_d;
    logic [N_REQ-1:0]        req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d;
    logic                    strobe_q, strobe_d, wr_en_q, wr_en_d, din_q, din_d;
    logic                    frame_bit, addr_bit;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .valid_i     (req_valid),
        .accept_i    (accept),
        .gnt_valid_o (gnt_valid),
        .gnt_idx_o   (gnt_idx),
        .gnt_oh_o    (gnt_oh)
    );

    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int r = 0; r < N_REQ; r++) begin
            if (gnt_idx == PTR_W'(r)) begin
                sel_write = req_write[r];
                sel_addr  = req_addr[r*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = req_wdata[r*REG_WIDTH +: REG_WIDTH];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt_q;
        accept      = 1'b0;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        rsp_rdata_d = rsp_rdata_q;
        req_ready_d = '0;
        rsp_valid_d = '0;
        sample_word = {dout, rdata_q};
        case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    accept      = 1'b1;
                    gnt_d       = gnt_idx;
                    write_d     = sel_write;
                    addr_d      = sel_addr;
                    wdata_d     = sel_wdata;
                    req_ready_d = gnt_oh;
                    state_d     = ST_SETUP;
                end
            end
            ST_SETUP:  state_d = ST_STROBE;
            ST_STROBE: begin
                state_d = ST_SHIFT;
                cnt_d   = '0;
            end
            ST_SHIFT: begin
                // Read data slots sample dout LSB first on the edge that ends each slot.
                if (!write_q && cnt_q >= FIRST_DATA) begin
                    rdata_d = sample_word[REG_WIDTH-1:1];
                end
                if (cnt_q == LAST_SLOT) begin
                    rsp_valid_d = N_REQ'(1) << gnt_q;
                    if (!write_q) begin
                        rsp_rdata_d = sample_word;
                    end
                    state_d = ST_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q == LAST_GAP) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Slave-facing outputs are precomputed for the next cycle so they leave the block registered.
    always_comb begin
        frame_bit = 1'b0;
        addr_bit  = 1'b0;
        for (int k = 0; k < FRAME_BITS; k++) begin
            if (cnt_d == CNT_W'(k)) frame_bit = (k < REG_WIDTH) ? wdata_q[k % REG_WIDTH]
                                                                : addr_q[(k - REG_WIDTH) % ADDR_WIDTH];
        end
        for (int k = 0; k < ADDR_WIDTH; k++) begin
            if (cnt_d == CNT_W'(k)) addr_bit = addr_q[k];
        end
        strobe_d = (state_d == ST_STROBE);
        wr_en_d  = (state_d inside {ST_SETUP, ST_STROBE, ST_SHIFT}) ? write_d : 1'b0;
        din_d    = 1'b0;
        if (state_d == ST_SHIFT) begin
            din_d = write_q ? frame_bit : addr_bit;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            gnt_q       <= '0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            rsp_rdata_q <= '0;
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            strobe_q    <= 1'b0;
            wr_en_q     <= 1'b0;
            din_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            strobe_q    <= strobe_d;
            wr_en_q     <= wr_en_d;
            din_q       <= din_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign busy      = (state_q != ST_IDLE);
    assign strobe    = strobe_q;
    assign wr_en     = wr_en_q;
    assign din       = din_q;

endmodule

// File: tb/tb_sipo_piso_master.sv
// tb/tb_sipo_piso_master.sv - self-checking bench for sipo_piso_master with a behavioural serial slave
module tb_sipo_piso_master;

    localparam int AW  = 5;
    localparam int RW  = 8;
    localparam int NR  = 2;
    localparam int GAP = 4;
    localparam int FB  = AW + RW;

    logic             clk = 1'b0;
    logic             rst;
    logic [NR-1:0]    req_valid, req_write, req_ready, rsp_valid;
    logic [NR*AW-1:0] req_addr;
    logic [NR*RW-1:0] req_wdata;
    logic [RW-1:0]    rsp_rdata;
    logic             busy, strobe, wr_en, din, dout;

    logic [RW-1:0]    slave_mem [32];
    logic [RW-1:0]    ref_mem   [32];
    logic [RW-1:0]    last_rdata;
    int               checks = 0;
    int               errors = 0;

    sipo_piso_master #(
        .ADDR_WIDTH (AW),
        .REG_WIDTH  (RW),
        .N_REQ      (NR),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .busy      (busy),
        .strobe    (strobe),
        .wr_en     (wr_en),
        .din       (din),
        .dout      (dout)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check(tag, 32'({req_ready, rsp_valid, busy, strobe, wr_en, din}), 32'd0);
    endtask

    // One request from requester r, with the slave decoding the serial frame it sees on din.
    task automatic do_txn(input int r, input logic wr, input logic [AW-1:0] addr,
                          input logic [RW-1:0] wdata, input int abort_slot);
        logic [FB-1:0] frame;
        logic [FB-1:0] s_bits;
        logic [RW-1:0] word;
        logic          exp_bit;
        int            n;
        frame  = {addr, wdata};
        s_bits = '0;
        req_write[r]            = wr;
        req_addr[r*AW +: AW]    = addr;
        req_wdata[r*RW +: RW]   = wdata;
        req_valid[r]            = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (req_ready === '0 && n < 60);
        check("grant_wait", 32'(n < 60), 32'd1);
        if (n >= 60) begin
            req_valid[r] = 1'b0;
            return;
        end
        check("req_ready", 32'(req_ready), 32'(1 << r));
        check("setup_wr_en", 32'(wr_en), 32'(wr));
        check("setup_strobe", 32'(strobe), 32'd0);
        check("setup_busy", 32'(busy), 32'd1);
        req_valid[r] = 1'b0;
        @(negedge clk);
        check("strobe_pulse", 32'(strobe), 32'd1);
        check("strobe_wr_en", 32'(wr_en), 32'(wr));
        check("strobe_ready_clear", 32'(req_ready), 32'd0);
        for (int k = 0; k < FB; k++) begin
            @(negedge clk);
            exp_bit = wr ? frame[k] : ((k < AW) ? addr[k] : 1'b0);
            check($sformatf("din_slot%0d", k), 32'(din), 32'(exp_bit));
            check("slot_wr_en", 32'(wr_en), 32'(wr));
            check("slot_quiet", 32'({strobe, rsp_valid}), 32'd0);
            s_bits[k] = din;
            if (!wr && k >= AW) begin
                word = slave_mem[s_bits[AW-1:0]];
                dout = word[k-AW];
            end else begin
                dout = 1'b0;
            end
            if (k == abort_slot) return;
        end
        if (wr) slave_mem[s_bits[FB-1:RW]] = s_bits[RW-1:0];
        if (wr) ref_mem[addr] = wdata;
        else    last_rdata    = ref_mem[addr];
        @(negedge clk);
        dout = 1'b0;
        check("rsp_valid", 32'(rsp_valid), 32'(1 << r));
        check("rsp_rdata", 32'(rsp_rdata), 32'(last_rdata));
        check("gap_lines", 32'({strobe, wr_en, din}), 32'd0);
        repeat (GAP - 1) begin
            @(negedge clk);
            check("gap_busy", 32'({busy, rsp_valid}), 32'({1'b1, 2'b00}));
        end
        @(negedge clk);
        check("idle_after_gap", 32'(busy), 32'd0);
    endtask

    initial begin
        int           ng;
        int           n;
        logic [NR-1:0] gidx [8];
        int           gcyc [8];
        logic         seen;

        rst = 1'b1;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        dout      = 1'b0;
        last_rdata = '0;
        for (int i = 0; i < 32; i++) begin
            slave_mem[i] = 8'($urandom);
            ref_mem[i]   = slave_mem[i];
        end
        for (int i = 0; i < 8; i++) begin
            gidx[i] = '0;
            gcyc[i] = 0;
        end

        #3 rst = 1'b0;
        #1;
        check_quiet("reset_outputs");
        check("reset_rdata", 32'(rsp_rdata), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        do_txn(0, 1'b1, 5'd1, 8'h2B, -1);
        slave_mem[16] = 8'hA5;
        ref_mem[16]   = 8'hA5;
        do_txn(1, 1'b0, 5'd16, 8'h00, -1);

        // Both requesters held valid from reset: expect alternating grants 20 cycles apart.
        rst = 1'b0;
        req_write = 2'b11;
        req_addr  = {5'd3, 5'd2};
        req_wdata = {8'h33, 8'h22};
        req_valid = 2'b11;
        @(negedge clk);
        rst = 1'b1;
        last_rdata = '0;
        ng = 0;
        for (int c = 0; c < 70; c++) begin
            @(negedge clk);
            if (req_ready !== '0 && ng < 8) begin
                gidx[ng] = req_ready;
                gcyc[ng] = c;
                ng++;
            end
        end
        req_valid = '0;
        check("rr_grant_count", 32'(ng), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("rr_order", 32'(gidx[i]), (i % 2 == 0) ? 32'd1 : 32'd2);
            if (i > 0) check("rr_spacing", 32'(gcyc[i] - gcyc[i-1]), 32'd20);
        end
        n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("rr_drain", 32'(busy), 32'd0);

        // Requester 0 withdraws before any grant; requester 1 must win despite rr_ptr = 0.
        rst = 1'b0;
        req_write = 2'b01;
        req_addr  = {5'd4, 5'd3};
        req_valid = 2'b11;
        @(negedge clk);
        req_valid[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        last_rdata = '0;
        do_txn(1, 1'b1, 5'd4, 8'h5A, -1);

        for (int a = 0; a <= 16; a++) do_txn(int'($urandom_range(0, 1)), 1'b1, 5'(a), 8'($urandom), -1);
        for (int a = 0; a <= 16; a++) do_txn(int'($urandom_range(0, 1)), 1'b0, 5'(a), 8'h00, -1);

        // Reset in slot 6 of a write: frame is dropped, slave keeps its old value.
        do_txn(0, 1'b1, 5'd9, 8'h3C, 6);
        rst = 1'b0;
        #1;
        check_quiet("abort_outputs");
        check("abort_rdata", 32'(rsp_rdata), 32'd0);
        last_rdata = '0;
        dout = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        repeat (24) begin
            @(negedge clk);
            if (rsp_valid !== '0 || busy !== 1'b0) seen = 1'b1;
        end
        check("abort_no_rsp", 32'(seen), 32'd0);
        do_txn(0, 1'b0, 5'd9, 8'h00, -1);
        do_txn(1, 1'b1, 5'd9, 8'h3C, -1);
        do_txn(0, 1'b0, 5'd9, 8'h00, -1);

        for (int i = 0; i < 24; i++) begin
            do_txn(int'($urandom_range(0, 1)), 1'($urandom), 5'($urandom_range(0, 31)),
                   8'($urandom), -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sipo_piso_master.md
# sipo_piso_master

Master-side frame sequencer for the serial register interface of `sipo_piso`. Two on-chip requesters issue parallel register read/write requests; a round-robin arbiter grants one at a time. The block serialises each request into a `strobe`/`wr_en`/`din` frame, and for reads captures `dout` into a parallel response. It sits between the digital control logic and the `sipo_piso` slave and replaces bench-style bit-banging.

## Interface
- `ADDR_WIDTH`, default `` `ADDR_WIDTH `` (5): register address bits.
- `REG_WIDTH`, default `` `REG_WIDTH `` (8): register data bits.
- `N_REQ`, default 2: number of requesters; values 1..4 must be supported.
- `GAP_CYCLES`, default 4: idle cycles inserted after every frame; minimum 1.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  N_REQ  per-requester request pending.
- `req_write`  in  N_REQ  1 = write, 0 = read.
- `req_addr`  in  N_REQ*ADDR_WIDTH  packed addresses; requester r uses slice r.
- `req_wdata`  in  N_REQ*REG_WIDTH  packed write data.
- `req_ready`  out  N_REQ  one-hot, one-cycle grant/accept pulse.
- `rsp_valid`  out  N_REQ  one-hot, one-cycle completion pulse (reads and writes).
- `rsp_rdata`  out  REG_WIDTH  read data; valid with `rsp_valid`, held until next read completes.
- `busy`  out  1  high whenever the state is not IDLE.
- `strobe`  out  1  frame start pulse to slave.
- `wr_en`  out  1  frame direction to slave (1 = write).
- `din`  out  1  serial data to slave.
- `dout`  in  1  serial read data from slave.

## Operation
- States: IDLE, SETUP, STROBE, SHIFT, GAP.
- IDLE: if any `req_valid` is set, grant the lowest index at or after `rr_ptr`, with wrap-around. Pulse `req_ready[g]` and capture write/addr/wdata. Set `rr_ptr` = g+1 mod N_REQ. Go to SETUP.
- Requesters hold valid and fields stable until `req_ready`. Deasserting before the grant withdraws the request. `req_valid` is not sampled outside IDLE.
- SETUP (1 cycle): drive `wr_en` = captured write.
- STROBE (1 cycle): `strobe` = 1.
- SHIFT (13 slots, slot counter 0..12):
  - Write: slot k drives `din` = frame[k], where frame = {addr, wdata}. Data goes out first, LSB first, then address LSB first.
  - Read: slots 0..4 drive `din` = addr[k]. Slots 5..12 drive `din` = 0 and sample `dout` into rdata[k-5] at the rising edge ending that slot.
- After slot 12: pulse `rsp_valid[g]`. For reads, update `rsp_rdata`. Go to GAP.
- GAP: `GAP_CYCLES` cycles with `strobe` = `wr_en` = `din` = 0. Then return to IDLE.
- Reset values, asynchronous on `rst` low: `strobe`, `wr_en`, `din`, `req_ready`, `rsp_valid`, `busy` = 0; `rsp_rdata` = 0; `rr_ptr` = 0; state = IDLE; slot counter = 0.
- Reset mid-frame aborts the frame: no `rsp_valid` is issued and the requester must reissue.
- Addresses are not range-checked; the slave owns decoding.
- Frame width is fixed at ADDR_WIDTH+REG_WIDTH; the slot counter wraps only via its state transition.

## Timing
- Grant at cycle G (IDLE). SETUP at G+1. STROBE at G+2. Slots 0..12 at G+3..G+15.
- `rsp_valid` at G+16, coincident with the first GAP cycle.
- Earliest next grant at G+16+GAP_CYCLES. Back-to-back period is 16+GAP_CYCLES cycles (20 by default).
- `wr_en` is stable from SETUP through slot 12, so it leads `strobe` by one cycle.
- All slave-facing outputs are registered with no combinational path from `dout` or `req_*`.
- `req_ready` and `rsp_valid` are registered pulses exactly one cycle wide.

## Structure
- `config.v` owns `ADDR_WIDTH`, `REG_WIDTH`, the `FRAME_BITS` (= sum) define, and the state encoding defines. These are shared with `sipo_piso` and benches.
- One sub-module: `rr_arbiter` (N_REQ-wide; combinational grant from valid and pointer, registered pointer update on accept).

## Test plan
- Write, requester 0, addr 5'd1, data 8'h2B → `strobe` at G+2; `din` slots 0..12 = bits of 13'h12B, LSB first; `wr_en` = 1 through G+15; `rsp_valid` = 2'b01 at G+16.
- Read, requester 1, addr 5'd16, behavioural slave returns 8'hA5 → `din` slots 0..4 = 0,0,0,0,1; `rsp_rdata` = 8'hA5 with `rsp_valid` = 2'b10 at G+16.
- Both requesters valid continuously, after reset → grants 0,1,0,1; grants 20 cycles apart; `rr_ptr` alternates.
- Write all 17 addresses (0..16) then read back via slave model → every read equals the written value.
- `rst` low during slot 6 of a write → all outputs 0 immediately; no `rsp_valid`; a new request is granted normally after release.
- Requester 0 drops `req_valid` before grant while requester 1 is valid → requester 1 granted; `req_ready[0]` never pulses.
